// File: rtl/credit_issue_scheduler.sv
// credit_issue_scheduler
//
// In-order NPU instruction scheduler between the instruction buffer and the
// decoder. Instructions are buffered in a power-of-two FIFO and staged through
// a registered head slot. Issue of the head is gated per execution unit by the
// unit's busy flag and by a credit counter of outstanding operations. SYNC
// waits until every unit is idle with no outstanding operations. Also
// provides flush, a stall watchdog and a sticky credit-underflow error flag.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   inst_valid     instruction offered            inst_in      instruction
//   inst_ready     = !queue_full
//   sched_valid    head instruction issuable      sched_inst   registered head
//   sched_ready    decoder accepts the head
//   flush          discard all queued and staged instructions
//   unit_busy      busy flags  [0] conv [1] pool [2] act [3] dma
//   unit_done      one-cycle completion pulses, same bit mapping
//   queue_empty    FIFO count == 0                queue_full   FIFO count == depth
//   queue_count    FIFO entries (head slot not counted)
//   head_valid     head slot occupied
//   stall_timeout  watchdog expired
//   err_underflow  sticky: completion arrived with no outstanding operation

package npu_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_CONV   = 4'h1,
        OP_FC     = 4'h2,
        OP_POOL   = 4'h3,
        OP_ACT    = 4'h4,
        OP_LOAD   = 4'h5,
        OP_STORE  = 4'h6,
        OP_ADD    = 4'h7,
        OP_MUL    = 4'h8,
        OP_CONCAT = 4'h9,
        OP_SPLIT  = 4'hA,
        OP_SYNC   = 4'hB
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [27:0] operand;
    } instruction_t;

endpackage

module credit_issue_scheduler
    import npu_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH     = 16,   // power of two, >= 2
    parameter int unsigned MAX_OUTSTANDING = 4,    // >= 1
    parameter int unsigned STALL_LIMIT     = 1024  // >= 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inst_valid,
    input  instruction_t                  inst_in,
    output logic                          inst_ready,
    output logic                          sched_valid,
    output instruction_t                  sched_inst,
    input  logic                          sched_ready,
    input  logic                          flush,
    input  logic [3:0]                    unit_busy,
    input  logic [3:0]                    unit_done,
    output logic                          queue_empty,
    output logic                          queue_full,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic                          head_valid,
    output logic                          stall_timeout,
    output logic                          err_underflow
);

    localparam int unsigned NumUnits = 4;
    localparam int unsigned AW       = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned OW       = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WW       = $clog2(STALL_LIMIT + 1);

    // State
    instruction_t   mem_q [QUEUE_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    instruction_t   head_q, head_d;
    logic           head_valid_q, head_valid_d;
    logic [OW-1:0]  credit_q [NumUnits];
    logic [OW-1:0]  credit_d [NumUnits];
    logic [WW-1:0]  wd_q, wd_d;
    logic           err_q, err_d;

    // Combinational control
    logic           empty, full;
    logic           wr_en, refill, issue, issuable;
    logic           head_mapped, head_sync, all_idle;
    logic [1:0]     head_unit;
    logic [3:0]     credit_inc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(QUEUE_DEPTH));

    // Map the head opcode onto its execution unit.
    always_comb begin
        head_mapped = 1'b1;
        head_unit   = 2'd0;
        head_sync   = 1'b0;
        case (head_q.opcode)
            OP_CONV, OP_FC:    head_unit = 2'd0;
            OP_POOL:           head_unit = 2'd1;
            OP_ACT:            head_unit = 2'd2;
            OP_LOAD, OP_STORE: head_unit = 2'd3;
            OP_SYNC: begin
                head_mapped = 1'b0;
                head_sync   = 1'b1;
            end
            default:           head_mapped = 1'b0;
        endcase
    end

    // SYNC is a completion barrier: nothing busy and nothing in flight.
    always_comb begin
        all_idle = (unit_busy == 4'b0000);
        for (int u = 0; u < NumUnits; u++) begin
            if (credit_q[u] != '0) begin
                all_idle = 1'b0;
            end
        end
    end

    always_comb begin
        if (head_sync) begin
            issuable = all_idle;
        end else if (head_mapped) begin
            issuable = !unit_busy[head_unit] &&
                       (credit_q[head_unit] < OW'(MAX_OUTSTANDING));
        end else begin
            issuable = 1'b1;
        end
    end

    assign sched_valid = head_valid_q && issuable;
    assign issue       = sched_valid && sched_ready;

    // Flush wins over write and refill; an issue in the flush cycle still stands.
    assign wr_en  = inst_valid && !full && !flush;
    assign refill = (!head_valid_q || issue) && !empty && !flush;

    // FIFO pointers, count and head slot
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        head_d       = head_q;
        head_valid_d = head_valid_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            head_valid_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (refill) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                head_d       = mem_q[rd_ptr_q];
                head_valid_d = 1'b1;
            end else if (issue) begin
                head_valid_d = 1'b0;
            end
            if (wr_en && !refill) begin
                count_d = count_q + CW'(1);
            end else if (!wr_en && refill) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Credits: +1 on issue to the unit, -1 on its done pulse.
    always_comb begin
        err_d = err_q;
        for (int u = 0; u < NumUnits; u++) begin
            credit_inc[u] = issue && head_mapped && (head_unit == 2'(u));
            credit_d[u]   = credit_q[u];
            if (credit_inc[u] && !unit_done[u]) begin
                credit_d[u] = credit_q[u] + OW'(1);
            end else if (!credit_inc[u] && unit_done[u]) begin
                if (credit_q[u] == '0) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[u] = credit_q[u] - OW'(1);
                end
            end
        end
    end

    // Watchdog counts cycles a held head fails to issue, saturating at the limit.
    always_comb begin
        wd_d = wd_q;
        if (flush || !head_valid_q || issue) begin
            wd_d = '0;
        end else if (wd_q != WW'(STALL_LIMIT)) begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            head_valid_q <= 1'b0;
            wd_q         <= '0;
            err_q        <= 1'b0;
            for (int u = 0; u < NumUnits; u++) begin
                credit_q[u] <= '0;
            end
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            head_valid_q <= head_valid_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            for (int u = 0; u < NumUnits; u++) begin
                credit_q[u] <= credit_d[u];
            end
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            mem_q[wr_ptr_q] <= inst_in;
        end
    end

    assign inst_ready    = !full;
    assign sched_inst    = head_q;
    assign queue_empty   = empty;
    assign queue_full    = full;
    assign queue_count   = count_q;
    assign head_valid    = head_valid_q;
    assign stall_timeout = (wd_q == WW'(STALL_LIMIT));
    assign err_underflow = err_q;

endmodule

// File: doc/credit_issue_scheduler.md
# credit_issue_scheduler

Parametrised successor to the in-order NPU instruction scheduler. It sits between the instruction buffer and the decoder. Instructions are buffered in a power-of-two FIFO and staged through a registered head slot. Issue is gated per execution unit by both the unit's busy flag and a credit counter of outstanding (issued, not yet done) operations. SYNC acts as a true completion barrier, and the block adds flush, a stall watchdog and a credit-underflow error flag.

## Interface
Parameters:
- QUEUE_DEPTH, 16: FIFO entries; power of two, ≥2.
- MAX_OUTSTANDING, 4: max in-flight ops per unit; ≥1.
- STALL_LIMIT, 1024: watchdog threshold in cycles; ≥1.

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- inst_valid  in  1  instruction offered.
- inst_in  in  instruction_t  instruction (npu_pkg).
- inst_ready  out  1  = !queue_full.
- sched_valid  out  1  head instruction issuable.
- sched_inst  out  instruction_t  registered head instruction.
- sched_ready  in  1  decoder accepts.
- flush  in  1  discard all queued and staged instructions.
- unit_busy  in  4  busy flags: [0] conv, [1] pool, [2] act, [3] dma.
- unit_done  in  4  one-cycle completion pulses, same bit mapping.
- queue_empty  out  1  FIFO count == 0.
- queue_full  out  1  FIFO count == QUEUE_DEPTH.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  FIFO entries; the head slot is not counted.
- head_valid  out  1  head slot occupied.
- stall_timeout  out  1  watchdog expired.
- err_underflow  out  1  sticky: a done pulse arrived with zero outstanding.

## Operation
- Unit map:
  - OP_CONV, OP_FC → unit 0.
  - OP_POOL → unit 1.
  - OP_ACT → unit 2.
  - OP_LOAD, OP_STORE → unit 3.
  - OP_ADD, OP_MUL, OP_CONCAT, OP_SPLIT, OP_NOP and any other opcode → no unit.
- Write: inst_valid && !queue_full writes the FIFO at wr_ptr; the pointer wraps modulo QUEUE_DEPTH.
- Head refill: when (!head_valid || issue) && !queue_empty, the FIFO entry at rd_ptr moves into the head slot.
  - Issue and refill in the same cycle give back-to-back issue.
  - If issue happens and the FIFO is empty, head_valid clears.
- Count: accept and refill in the same cycle leave the count unchanged.
- Issue rules, evaluated on the head slot:
  - Unit op: issuable when !unit_busy[u] && outstanding[u] < MAX_OUTSTANDING.
  - OP_SYNC: issuable when every outstanding[u] == 0 and unit_busy == 0.
  - Unmapped ops: always issuable.
  - sched_valid = head_valid && issuable; issue = sched_valid && sched_ready.
- Credits: outstanding[u] has width $clog2(MAX_OUTSTANDING+1).
  - +1 on issue of an op mapped to unit u.
  - −1 on unit_done[u].
  - Both in the same cycle: unchanged.
  - unit_done[u] while outstanding[u] == 0: counter stays 0 and err_underflow sets; it clears only on reset.
- Flush: next edge clears FIFO pointers, count and head_valid.
  - Flush has priority over a write and a refill in the same cycle; inst_in is dropped.
  - Credits are not cleared: in-flight ops still complete.
  - A flush-cycle handshake still counts as issued (credit increments).
- Watchdog: counter increments each cycle head_valid && !issue, saturating at STALL_LIMIT.
  - stall_timeout = (counter == STALL_LIMIT).
  - Counter clears on issue, on flush, or when the head slot is empty.

## Timing
- Reset values: FIFO empty, head_valid=0, sched_valid=0, credits 0, watchdog 0.
  - Outputs: inst_ready=1, queue_empty=1, queue_full=0, queue_count=0, stall_timeout=0, err_underflow=0.
- Latency: an instruction accepted at edge k into an empty block loads the head slot at edge k+1. sched_valid can rise in the cycle after edge k+1 (two-cycle minimum).
- sched_inst is stable while head_valid && !issue.
- sched_valid may rise or fall with unit_busy or credits while the head is held; the decoder must not rely on sched_valid being sticky.
- Credit updates from an issue at edge k gate the next head from cycle k+1 onward.
- A done pulse at edge k frees the credit for issue in cycle k+1.
- Reset asserted mid-operation returns every register to its reset value at the next edge, regardless of other inputs.

## Test plan
- Push CONV, POOL, NOP with sched_ready=1 and all units idle → sched_valid first high 2 cycles after the first accept; all three issue on consecutive cycles.
- MAX_OUTSTANDING=2: push 3 CONV with no unit_done → 2 issue; the third holds sched_valid=0. Pulse unit_done[0] → the third issues on the next cycle.
- LOAD issued (credit 1), then SYNC at head → sched_valid=0 until unit_done[3]; SYNC issues the cycle after.
- Fill 16 + head with sched_ready=0 → queue_full=1, inst_ready=0, queue_count=16, extra pushes dropped. Then 17 pops → the data order matches across the pointer wrap.
- Mid-stream flush with inst_valid=1 → the next cycle shows queue_count=0, head_valid=0, the flush-cycle instruction dropped, and credits unchanged.
- STALL_LIMIT=8, head CONV with unit_busy[0]=1 held → stall_timeout rises after 8 stalled cycles and clears the cycle after issue. unit_done[1] with zero credit → err_underflow=1, sticky until reset.
